// File: rtl/fir_sched_pkg.sv
// Shared definitions for the time-multiplexed FIR sequencer: default build
// configuration, derived widths, output clamp bounds and the FSM encoding.
package fir_sched_pkg;

    localparam int DEF_IW    = 8;
    localparam int DEF_CW    = 8;
    localparam int DEF_OW    = 8;
    localparam int DEF_NTAPS = 16;
    localparam int DEF_SHIFT = 7;

    // Derived widths for the default configuration
    localparam int AW   = $clog2(DEF_NTAPS);
    localparam int PW   = DEF_IW + DEF_CW;
    localparam int ACCW = PW + AW;

    // Output clamp bounds for the default output width
    localparam int SAT_MAX = (2 ** (DEF_OW - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DEF_OW - 1));

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        IDLE  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/fir_mac_datapath.sv
// Shared multiply-accumulate datapath: product register, accumulator with
// clear/enable, and round-half-up plus saturation into the output register.
module fir_mac_datapath
    import fir_sched_pkg::*;
#(
    parameter int IW    = DEF_IW,
    parameter int CW    = DEF_CW,
    parameter int OW    = DEF_OW,
    parameter int NTAPS = DEF_NTAPS,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic signed [IW-1:0] i_sample,
    input  logic signed [CW-1:0] i_coef,
    input  logic                 i_mul_en,
    input  logic                 i_acc_clr,
    input  logic                 i_acc_en,
    input  logic                 i_out_en,
    output logic signed [OW-1:0] o_data
);

    localparam int PROD_W = IW + CW;
    localparam int ACC_W  = PROD_W + $clog2(NTAPS);
    localparam int RND_W  = ACC_W + 1;

    localparam logic signed [RND_W-1:0] RND_BIAS = RND_W'(2 ** (SHIFT - 1));
    localparam logic signed [RND_W-1:0] OUT_MAX  = RND_W'((2 ** (OW - 1)) - 1);
    localparam logic signed [RND_W-1:0] OUT_MIN  = RND_W'(-(2 ** (OW - 1)));

    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] coef_ext;
    logic signed [PROD_W-1:0] prod_reg;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [RND_W-1:0]  rounded;
    logic signed [OW-1:0]     sat_val;
    logic signed [OW-1:0]     data_reg;

    assign sample_ext = $signed({{(PROD_W - IW){i_sample[IW-1]}}, i_sample});
    assign coef_ext   = $signed({{(PROD_W - CW){i_coef[CW-1]}}, i_coef});
    assign prod_ext   = $signed({{(ACC_W - PROD_W){prod_reg[PROD_W-1]}}, prod_reg});

    // Product stage: register the signed sample x coefficient product
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            prod_reg <= '0;
        end else if (i_mul_en) begin
            prod_reg <= sample_ext * coef_ext;
        end
    end

    // Running sum including the product landing this cycle
    always_comb begin
        acc_next = acc_reg;
        if (i_acc_en) begin
            acc_next = acc_reg + prod_ext;
        end
    end

    // Accumulator register; clearing wins so a new sample starts from zero
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_reg <= '0;
        end else if (i_acc_clr) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    // Round half up with an arithmetic shift, then clamp to the output range
    always_comb begin
        rounded = ($signed({acc_next[ACC_W-1], acc_next}) + RND_BIAS) >>> SHIFT;
        if (rounded > OUT_MAX) begin
            sat_val = OUT_MAX[OW-1:0];
        end else if (rounded < OUT_MIN) begin
            sat_val = OUT_MIN[OW-1:0];
        end else begin
            sat_val = rounded[OW-1:0];
        end
    end

    // Output register: captures the final sum and holds it until the next result
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            data_reg <= '0;
        end else if (i_out_en) begin
            data_reg <= sat_val;
        end
    end

    assign o_data = data_reg;

endmodule

// File: rtl/fir_mac_scheduler.sv
// Sequencer for a time-multiplexed FIR: accepts one sample per handshake into a
// circular history, walks the shared MAC over every tap, owns the coefficient
// RAM, and emits one rounded, saturated result with a single-cycle strobe.
module fir_mac_scheduler
    import fir_sched_pkg::*;
#(
    parameter int IW    = DEF_IW,
    parameter int CW    = DEF_CW,
    parameter int OW    = DEF_OW,
    parameter int NTAPS = DEF_NTAPS,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_ce,
    input  logic signed [IW-1:0]       i_data,
    output logic                       o_busy,
    input  logic                       i_tap_wr,
    input  logic [$clog2(NTAPS)-1:0]   i_tap_addr,
    input  logic signed [CW-1:0]       i_tap_data,
    output logic                       o_tap_err,
    output logic                       o_ce,
    output logic signed [OW-1:0]       o_data
);

    localparam int TAP_AW = $clog2(NTAPS);
    localparam logic [TAP_AW-1:0] LAST_TAP   = TAP_AW'(NTAPS - 1);
    localparam logic [TAP_AW-1:0] FLUSH_LAST = TAP_AW'(1);

    state_t state_reg;
    state_t state_next;

    logic [TAP_AW-1:0] wptr_reg;
    logic [TAP_AW-1:0] wptr_next;
    logic [TAP_AW-1:0] tap_cnt_reg;
    logic [TAP_AW-1:0] tap_cnt_next;

    logic accept;
    logic coef_wr_ok;
    logic out_en;

    logic signed [IW-1:0] sample_ram [NTAPS];
    logic signed [CW-1:0] coef_ram   [NTAPS];

    logic                 sample_we;
    logic [TAP_AW-1:0]    sample_waddr;
    logic signed [IW-1:0] sample_wdata;
    logic [TAP_AW-1:0]    sample_raddr;
    logic                 coef_we;
    logic [TAP_AW-1:0]    coef_waddr;
    logic signed [CW-1:0] coef_wdata;

    logic signed [IW-1:0] sample_q_reg;
    logic signed [CW-1:0] coef_q_reg;

    logic rd_vld_reg;
    logic prod_vld_reg;
    logic ce_reg;
    logic tap_err_reg;

    // State, write pointer and tap counter registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg   <= CLEAR;
            wptr_reg    <= '0;
            tap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            wptr_reg    <= wptr_next;
            tap_cnt_reg <= tap_cnt_next;
        end
    end

    // Next-state logic: CLEAR and RUN span NTAPS cycles, FLUSH spans two
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CLEAR:   if (tap_cnt_reg == LAST_TAP) state_next = IDLE;
            IDLE:    if (i_ce) state_next = RUN;
            RUN:     if (tap_cnt_reg == LAST_TAP) state_next = FLUSH;
            FLUSH:   if (tap_cnt_reg == FLUSH_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    // Tap counter restarts on every state change; write pointer wraps freely
    always_comb begin
        tap_cnt_next = tap_cnt_reg + 1'b1;
        if (state_next != state_reg) begin
            tap_cnt_next = '0;
        end
        wptr_next = wptr_reg;
        if (accept) begin
            wptr_next = wptr_reg + 1'b1;
        end
    end

    // Output and RAM-port decode from the current state
    always_comb begin
        o_busy       = (state_reg != IDLE);
        accept       = (state_reg == IDLE) && i_ce;
        coef_wr_ok   = (state_reg == IDLE) && i_tap_wr;
        out_en       = (state_reg == FLUSH) && (tap_cnt_reg == FLUSH_LAST);

        sample_we    = accept;
        sample_waddr = wptr_reg;
        sample_wdata = i_data;
        coef_we      = coef_wr_ok;
        coef_waddr   = i_tap_addr;
        coef_wdata   = i_tap_data;
        if (state_reg == CLEAR) begin
            sample_we    = 1'b1;
            sample_waddr = tap_cnt_reg;
            sample_wdata = '0;
            coef_we      = 1'b1;
            coef_waddr   = tap_cnt_reg;
            coef_wdata   = '0;
        end

        // Newest sample sits one behind the write pointer; tap k looks k further back
        sample_raddr = wptr_reg - 1'b1 - tap_cnt_reg;
    end

    // Sample history RAM with registered read
    always_ff @(posedge i_clk) begin
        if (sample_we) begin
            sample_ram[sample_waddr] <= sample_wdata;
        end
        sample_q_reg <= sample_ram[sample_raddr];
    end

    // Coefficient RAM with registered read, indexed directly by tap number
    always_ff @(posedge i_clk) begin
        if (coef_we) begin
            coef_ram[coef_waddr] <= coef_wdata;
        end
        coef_q_reg <= coef_ram[tap_cnt_reg];
    end

    // Pipeline valids, result strobe and dropped-write error pulse
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_vld_reg   <= 1'b0;
            prod_vld_reg <= 1'b0;
            ce_reg       <= 1'b0;
            tap_err_reg  <= 1'b0;
        end else begin
            rd_vld_reg   <= (state_reg == RUN);
            prod_vld_reg <= rd_vld_reg;
            ce_reg       <= out_en;
            tap_err_reg  <= i_tap_wr && (state_reg != IDLE);
        end
    end

    assign o_ce      = ce_reg;
    assign o_tap_err = tap_err_reg;

    fir_mac_datapath #(
        .IW    (IW),
        .CW    (CW),
        .OW    (OW),
        .NTAPS (NTAPS),
        .SHIFT (SHIFT)
    ) u_datapath (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_sample  (sample_q_reg),
        .i_coef    (coef_q_reg),
        .i_mul_en  (rd_vld_reg),
        .i_acc_clr (accept),
        .i_acc_en  (prod_vld_reg),
        .i_out_en  (out_en),
        .o_data    (o_data)
    );

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler: a behavioural convolution model with a
// cycle-level timing expectation, checked every cycle, plus directed vectors
// whose results are pinned to hand-computed literals.
module tb_fir_mac_scheduler;
    import fir_sched_pkg::*;

    localparam int NTAPS = DEF_NTAPS;
    localparam int SHIFT = DEF_SHIFT;
    localparam int LAT   = NTAPS + 3;

    logic                    i_clk = 1'b0;
    logic                    i_reset_n;
    logic                    i_ce;
    logic signed [DEF_IW-1:0] i_data;
    logic                    o_busy;
    logic                    i_tap_wr;
    logic [AW-1:0]           i_tap_addr;
    logic signed [DEF_CW-1:0] i_tap_data;
    logic                    o_tap_err;
    logic                    o_ce;
    logic signed [DEF_OW-1:0] o_data;

    int n_vec  = 0;
    int n_miss = 0;

    // Model state
    int cyc         = 0;
    int busy_left   = NTAPS;
    int exp_ce_cyc  = -1;
    int exp_y       = 0;
    int last_out    = 0;
    bit err_due     = 1'b0;
    int hist [NTAPS];
    int coef [NTAPS];
    int n_acc = 0;
    int n_oce = 0;
    int n_err = 0;
    int dut_out[$];
    int mdl_out[$];

    fir_mac_scheduler dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_ce       (i_ce),
        .i_data     (i_data),
        .o_busy     (o_busy),
        .i_tap_wr   (i_tap_wr),
        .i_tap_addr (i_tap_addr),
        .i_tap_data (i_tap_data),
        .o_tap_err  (o_tap_err),
        .o_ce       (o_ce),
        .o_data     (o_data)
    );

    always #5 i_clk = ~i_clk;

    function automatic void check(string name, int got, int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // y = sum_k h[k] * x[n-k], rounded half up after the shift, clamped
    function automatic int model_y();
        logic signed [ACCW-1:0] acc;
        logic signed [PW-1:0]   p;
        longint r;
        acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            p   = PW'(hist[k] * coef[k]);
            acc = acc + ACCW'(p);
        end
        r = longint'(acc);
        r = (r + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        if (r > SAT_MAX) r = SAT_MAX;
        if (r < SAT_MIN) r = SAT_MIN;
        return int'(r);
    endfunction

    function automatic int get_out(int idx);
        if (idx < dut_out.size()) return dut_out[idx];
        return -9999;
    endfunction

    // Compare process: outputs sampled mid-cycle, model advanced with the inputs
    // that the next rising edge will see
    always @(negedge i_clk) begin
        cyc++;
        if (!i_reset_n) begin
            check("rst_busy", int'(o_busy), 1);
            check("rst_ce", int'(o_ce), 0);
            check("rst_data", int'(o_data), 0);
            check("rst_tap_err", int'(o_tap_err), 0);
            busy_left  = NTAPS;
            exp_ce_cyc = -1;
            last_out   = 0;
            err_due    = 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                hist[k] = 0;
                coef[k] = 0;
            end
        end else begin
            check("busy", int'(o_busy), (busy_left > 0) ? 1 : 0);
            check("ce", int'(o_ce), (cyc == exp_ce_cyc) ? 1 : 0);
            if (cyc == exp_ce_cyc) last_out = exp_y;
            check("data", int'(o_data), last_out);
            check("tap_err", int'(o_tap_err), err_due ? 1 : 0);
            if (o_ce) begin
                dut_out.push_back(int'(o_data));
                n_oce++;
            end
            if (o_tap_err) n_err++;

            err_due = i_tap_wr && (busy_left > 0);
            if (i_tap_wr && busy_left == 0) coef[i_tap_addr] = int'(i_tap_data);
            if (i_ce && busy_left == 0) begin
                for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = int'(i_data);
                exp_y = model_y();
                mdl_out.push_back(exp_y);
                exp_ce_cyc = cyc + LAT;
                busy_left  = LAT;
                n_acc++;
            end else if (busy_left > 0) begin
                busy_left--;
            end
        end
    end

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy_left > 0 && g < 200) begin
            @(posedge i_clk); #1;
            g++;
        end
        if (busy_left > 0) check("idle_timeout", 1, 0);
    endtask

    task automatic send(input int x);
        int a0;
        int g;
        a0 = n_acc;
        i_ce   = 1'b1;
        i_data = DEF_IW'(x);
        g = 0;
        while (n_acc == a0 && g < 100) begin
            @(posedge i_clk); #1;
            g++;
        end
        if (n_acc == a0) check("accept_timeout", 1, 0);
        i_ce = 1'b0;
    endtask

    task automatic wr_tap(input int a, input int d);
        wait_idle();
        i_tap_wr   = 1'b1;
        i_tap_addr = AW'(a);
        i_tap_data = DEF_CW'(d);
        @(posedge i_clk); #1;
        i_tap_wr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int b;
        int s0;
        int s1;
        i_reset_n = 1'b0; i_ce = 1'b0; i_data = '0;
        i_tap_wr = 1'b0; i_tap_addr = '0; i_tap_data = '0;
        repeat (3) @(posedge i_clk);
        #1 i_reset_n = 1'b1;

        // Busy span after reset release
        cnt = 0;
        for (int g = 0; g < 100; g++) begin
            @(negedge i_clk);
            if (o_busy) cnt++;
            else break;
        end
        check("clear_len", cnt, 16);

        // Sparse filter: h0 = 64, h3 = -32, impulse of 100
        wr_tap(0, 64);
        wr_tap(3, -32);
        b = dut_out.size();
        send(100);
        for (int i = 0; i < 19; i++) send(0);
        wait_idle();
        check("imp_y0", get_out(b + 0), 50);
        check("imp_y1", get_out(b + 1), 0);
        check("imp_y2", get_out(b + 2), 0);
        check("imp_y3", get_out(b + 3), -25);
        check("imp_y4", get_out(b + 4), 0);
        check("imp_y19", get_out(b + 19), 0);
        check("mdl_y0", mdl_out[b + 0], 50);
        check("mdl_y3", mdl_out[b + 3], -25);

        // Coefficient write during RUN is dropped and flagged
        s0 = n_err;
        b  = dut_out.size();
        send(100);
        repeat (2) @(posedge i_clk);
        #1;
        i_tap_wr = 1'b1; i_tap_addr = '0; i_tap_data = 8'sd10;
        @(posedge i_clk); #1;
        i_tap_wr = 1'b0;
        wait_idle();
        check("run_wr_old_coef", get_out(b), 50);
        check("run_wr_err_pulses", n_err - s0, 1);

        // Coefficient write with an accepted sample: new coefficient is used
        wait_idle();
        b = dut_out.size();
        i_tap_wr = 1'b1; i_tap_addr = '0; i_tap_data = 8'sd32;
        send(100);
        i_tap_wr = 1'b0;
        wait_idle();
        check("same_cycle_wr", get_out(b), 25);

        // Saturation both ways
        for (int k = 0; k < NTAPS; k++) wr_tap(k, 127);
        b = dut_out.size();
        for (int i = 0; i < NTAPS; i++) send(127);
        wait_idle();
        check("sat_pos", get_out(b + NTAPS - 1), 127);
        check("mdl_sat_pos", mdl_out[b + NTAPS - 1], 127);
        b = dut_out.size();
        for (int i = 0; i < NTAPS; i++) send(-128);
        wait_idle();
        check("sat_neg", get_out(b + NTAPS - 1), -128);
        check("mdl_sat_neg", mdl_out[b + NTAPS - 1], -128);

        // Continuous valid for 200 clocks
        wait_idle();
        s0 = n_oce;
        s1 = n_acc;
        i_ce = 1'b1; i_data = 8'sd3;
        repeat (200) @(posedge i_clk);
        #1 i_ce = 1'b0;
        check("stream_oce", n_oce - s0, 10);
        check("stream_accepts", n_acc - s1, 10);
        wait_idle();

        // Reset during RUN tap 5 aborts the sample
        s0 = n_oce;
        send(100);
        repeat (5) @(posedge i_clk);
        #1 i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        repeat (30) @(posedge i_clk);
        #1;
        check("abort_no_ce", n_oce - s0, 0);
        wait_idle();
        b = dut_out.size();
        send(100);
        wait_idle();
        check("post_reset_ce", n_oce - s0, 1);
        check("post_reset_y", get_out(b), 0);

        repeat (3) @(posedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
